// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and status out
interface uart_rx_if;
    logic       sci_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  sci_rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output sci_rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, framing-error pulse
module uart_rx #(
    parameter int TD      = 2604,
    parameter int TD_HALF = 1302
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master rx
);
    localparam int CW = ($clog2(TD) > 16) ? $clog2(TD) : 16;
    localparam logic [CW-1:0] TD_LAST   = CW'(TD - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(TD_HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic          prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync1        <= 1'b1;
            rx_s         <= 1'b1;
            prev         <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx.rx_data   <= 8'h00;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.rx_busy   <= 1'b0;
        end else begin
            sync1        <= rx.sci_rx;
            rx_s         <= sync1;
            prev         <= rx_s;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    // Needs a real 1->0 transition, so a held-low break never retriggers
                    if (prev && !rx_s) begin
                        state      <= START;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        rx.rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state      <= IDLE;
                            rx.rx_busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == TD_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == TD_LAST) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        rx.rx_busy <= 1'b0;
                        if (rx_s) begin
                            rx.rx_data  <= shreg;
                            rx.rx_valid <= 1'b1;
                        end else begin
                            rx.frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    rx.rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if u_if ();
    uart_rx_if u_if_b ();

    uart_rx #(.TD(16), .TD_HALF(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (u_if.master)
    );

    uart_rx #(.TD(2604), .TD_HALF(1302)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (u_if_b.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int         v_cnt = 0, f_cnt = 0, v_cyc = 0, f_cyc = 0, both_cnt = 0, long_cnt = 0;
    int         bv_cnt = 0, bf_cnt = 0;
    logic [7:0] v_data = 8'h00, bv_data = 8'h00;
    logic       v_d = 1'b0, f_d = 1'b0;

    always @(negedge clk) begin
        if (u_if.rx_valid) begin
            v_cnt++;
            v_cyc  = cyc;
            v_data = u_if.rx_data;
        end
        if (u_if.frame_err) begin
            f_cnt++;
            f_cyc = cyc;
        end
        if (u_if.rx_valid && u_if.frame_err) both_cnt++;
        if ((u_if.rx_valid && v_d) || (u_if.frame_err && f_d)) long_cnt++;
        v_d = u_if.rx_valid;
        f_d = u_if.frame_err;
        if (u_if_b.rx_valid) begin
            bv_cnt++;
            bv_data = u_if_b.rx_data;
        end
        if (u_if_b.frame_err) bf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit big, input logic v);
        if (big) u_if_b.sci_rx = v;
        else     u_if.sci_rx   = v;
    endtask

    // Call at a negedge; line is left at the stop-bit level on return
    task automatic send_frame(input bit big, input logic [7:0] b, input logic stop_bit, input int bc);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        t0 = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            drive(big, fr[j]);
            repeat (bc) @(negedge clk);
        end
    endtask

    initial begin
        u_if.sci_rx   = 1'b1;
        u_if_b.sci_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  {24'h0, u_if.rx_data}, 32'h00);
        chk("reset_valid", {31'h0, u_if.rx_valid}, 32'h0);
        chk("reset_ferr",  {31'h0, u_if.frame_err}, 32'h0);
        chk("reset_busy",  {31'h0, u_if.rx_busy}, 32'h0);
        chk("reset_busy_big", {31'h0, u_if_b.rx_busy}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0xA5: sample edge E+152 with E = t0+2
        send_frame(1'b0, 8'hA5, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("a5_count", v_cnt, 1);
        chk("a5_data",  {24'h0, v_data}, 32'hA5);
        chk("a5_latency", v_cyc - t0, 154);
        chk("a5_ferr",  f_cnt, 0);

        // 3-cycle glitch: busy from E until the START sample at E+8
        t0 = cyc + 1;
        drive(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b1);
        chk("glitch_busy_rise", {31'h0, u_if.rx_busy}, 32'h1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_last", {31'h0, u_if.rx_busy}, 32'h1);
        @(negedge clk);
        chk("glitch_busy_fall", {31'h0, u_if.rx_busy}, 32'h0);
        repeat (20) @(negedge clk);
        chk("glitch_no_valid", v_cnt, 1);
        chk("glitch_no_ferr",  f_cnt, 0);

        // Bad stop bit, then a 40-cycle break
        send_frame(1'b0, 8'h3C, 1'b0, 16);
        repeat (40) @(negedge clk);
        chk("ferr_count",    f_cnt, 1);
        chk("ferr_latency",  f_cyc - t0, 154);
        chk("ferr_no_valid", v_cnt, 1);
        chk("ferr_data_kept", {24'h0, u_if.rx_data}, 32'hA5);
        chk("break_idle",    {31'h0, u_if.rx_busy}, 32'h0);
        drive(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("break_no_retrigger", v_cnt + f_cnt, 2);

        // Back-to-back frames, one stop bit each
        send_frame(1'b0, 8'h00, 1'b1, 16);
        chk("b2b_first_data", {24'h0, v_data}, 32'h00);
        send_frame(1'b0, 8'hFF, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("b2b_count", v_cnt, 3);
        chk("b2b_second_data", {24'h0, v_data}, 32'hFF);

        // Reset during data bit 4 (line high there and afterwards)
        fork
            send_frame(1'b0, 8'hF0, 1'b1, 16);
            begin
                repeat (86) @(negedge clk);
                chk("rst_mid_busy_before", {31'h0, u_if.rx_busy}, 32'h1);
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_mid_busy", {31'h0, u_if.rx_busy}, 32'h0);
                chk("rst_mid_data", {24'h0, u_if.rx_data}, 32'h00);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("rst_mid_no_pulse", v_cnt + f_cnt, 4);
        send_frame(1'b0, 8'h5A, 1'b1, 16);
        repeat (4) @(negedge clk);
        chk("after_rst_count", v_cnt, 4);
        chk("after_rst_data",  {24'h0, v_data}, 32'h5A);

        // Team transmitter timing: TD+1 cycles per bit at full rate
        send_frame(1'b1, 8'h81, 1'b1, 2605);
        repeat (10) @(negedge clk);
        chk("loop_81_count", bv_cnt, 1);
        chk("loop_81_data",  {24'h0, bv_data}, 32'h81);
        send_frame(1'b1, 8'h7E, 1'b1, 2605);
        repeat (10) @(negedge clk);
        chk("loop_7e_count", bv_cnt, 2);
        chk("loop_7e_data",  {24'h0, bv_data}, 32'h7E);
        chk("loop_no_ferr",  bf_cnt, 0);

        chk("never_both",     both_cnt, 0);
        chk("pulse_one_cycle", long_cnt, 0);
        chk("total_ferr",     f_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter TD, 2604, clock cycles per bit (25 MHz / 9600 baud); SHALL be >= 4.
REQ-002 Parameter TD_HALF, 1302, cycles from start edge to start-bit mid-sample; SHALL equal TD/2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sci_rx  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-006 rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-007 rx_valid  output  1  one-cycle pulse, rx_data updated in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse on stop bit sampled low.
REQ-009 rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 sci_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the stage-2 output, rx_s.
REQ-011 A prev register of rx_s (reset 1) SHALL detect a start edge: prev==1 and rx_s==0, evaluated only in IDLE.
REQ-012 States: IDLE, START, DATA, STOP; encoding is free; reset state is IDLE.
REQ-013 Let E = the cycle the start edge is detected; IDLE->START at E, bit counter cleared, cycle counter cleared.
REQ-014 START: sample rx_s at E+TD_HALF; if 1 -> false start, back to IDLE, no output pulse; if 0 -> DATA.
REQ-015 DATA: bit k (k=0..7) SHALL be sampled at E+TD_HALF+(k+1)*TD and shifted into bit position k of an internal shift register.
REQ-016 After bit 7 is sampled -> STOP.
REQ-017 STOP: sample at E+TD_HALF+9*TD; if 1 -> rx_data <= shift register and rx_valid=1 in the following cycle; if 0 -> frame_err=1 in the following cycle, rx_data unchanged.
REQ-018 After the stop sample the FSM SHALL return to IDLE; a new start edge is accepted from the cycle immediately after the stop sample.
REQ-019 A line held low after a framing error (break) SHALL NOT retrigger; a new frame requires a fresh 1->0 transition.
REQ-020 rx_valid and frame_err SHALL never be high together, and each SHALL be high for exactly one cycle per frame.
REQ-021 The cycle counter SHALL be at least 16 bits wide, count 0..TD-1 within DATA/STOP, and never wrap mid-bit.
REQ-022 Edges on rx_s outside IDLE SHALL be ignored; only the mid-bit samples are used.
REQ-023 A received bit period of TD+1 cycles (the team transmitter's timing) SHALL decode correctly; tolerated drift is +/-TD/20 per bit.

Reset
REQ-024 While rst_n==0 at a clock edge: state=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0, sync flops and prev=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse; reception restarts on the next start edge after release.

Verification (TD=16, TD_HALF=8 unless stated)
REQ-026 Frame 0xA5 with a good stop bit -> one rx_valid pulse at E+153, rx_data=8'hA5, frame_err stays 0.
REQ-027 sci_rx low glitch of 3 cycles while idle -> returns to IDLE at E+8, no rx_valid or frame_err, rx_busy low again.
REQ-028 Frame 0x3C with the stop bit driven low -> frame_err pulse, rx_valid 0, rx_data keeps its previous value (8'hA5); the line then held low 40 cycles -> no new frame.
REQ-029 Back-to-back frames 0x00 then 0xFF, one stop bit each -> two rx_valid pulses, rx_data 8'h00 then 8'hFF.
REQ-030 rst_n pulled low for 2 cycles during DATA bit 4 -> all outputs at reset values, no pulses; next frame 0x5A received correctly.
REQ-031 Loopback with the team transmitter at TD=2604: send 0x81, 0x7E -> rx_data matches each byte, frame_err never asserted.
